multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences each instruction over 3–5 cycles and drives all datapath mux selects and write enables.
- Memory accesses wait on a `MemReady` handshake, so fetch, load and store can stretch over multiple cycles.
- Sits between the instruction register (which supplies `OpCode`/`Funct`) and the shared-memory multi-cycle datapath. It also counts fetched instructions and flags illegal encodings.

Parameters:
- MEM_WAIT, 1, 1: FETCH/MEMRD/MEMWR hold until `MemReady`=1. 0: `MemReady` is ignored and treated as 1.
- ENABLE_ADDI, 1, 1: addi (opcode 001000) is supported. 0: addi is decoded as illegal.
- CNT_W, 32, width of the `InstrCount` counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- OpCode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- MemReady  in  1  memory completes the current access this cycle
- PCWr  out  1  unconditional PC write
- PCWrCond  out  1  PC write if ALU Zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRd  out  1  memory read request
- MemWr  out  1  memory write request
- IRWr  out  1  instruction register load
- RegDst  out  1  register write address: 1=Rd, 0=Rt
- RegWr  out  1  register file write
- Mem2Reg  out  1  write-back source: 1=MDR, 0=ALUOut
- ALUSrcA  out  1  ALU operand A: 0=PC, 1=A register
- ALUSrcB  out  2  ALU operand B: 00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- PCSrc  out  2  next PC source: 00=ALU result, 01=ALUOut, 10=jump target
- ALUCtr  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- Illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- State  out  4  current state encoding, for debug
- InstrCount  out  CNT_W  number of fetched instructions

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state ← IDLE, `InstrCount` ← 0. In IDLE every output is 0 (`ALUCtr`=0000, `State`=0).
- IDLE always goes to FETCH on the next edge. Reset asserted mid-instruction aborts immediately to IDLE; no partial write is completed.
- Outputs are decoded purely from the state register (Moore), except that `IRWr`/`PCWr` in FETCH are additionally gated by `MemReady`.
- Signals not listed for a state are 0. `ALUCtr` defaults to ADD where unlisted.
- State encodings and actions:
  - IDLE=0: all outputs 0.
  - FETCH=1: `MemRd`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, ADD, `PCSrc`=00. `IRWr`=`PCWr`=`MemReady`. Stays in FETCH while `MemReady`=0; goes to DECODE when `MemReady`=1. `InstrCount` increments (wrapping modulo 2^CNT_W) in that same cycle.
  - DECODE=2: `ALUSrcA`=0, `ALUSrcB`=11, ADD (branch target precompute). Next state by `OpCode`:
    - 000000 → EXEC if `Funct` ∈ {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}
    - 100011/101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDIEX if ENABLE_ADDI
    - anything else → FETCH, with `Illegal`=1 in this DECODE cycle only
  - MEMADR=3: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD=4: `MemRd`=1, `IorD`=1. Holds until `MemReady`, then goes to MEMWB.
  - MEMWB=5: `RegWr`=1, `RegDst`=0, `Mem2Reg`=1. Goes to FETCH.
  - MEMWR=6: `MemWr`=1, `IorD`=1. Holds until `MemReady`, then goes to FETCH. `MemWr` stays high for every wait cycle.
  - EXEC=7: `ALUSrcA`=1, `ALUSrcB`=00. `ALUCtr` from `Funct`: add→0010, sub→0110, and→0000, or→0001, slt→0111. Goes to ALUWB.
  - ALUWB=8: `RegWr`=1, `RegDst`=1, `Mem2Reg`=0. `ALUCtr` holds the EXEC value. Goes to FETCH.
  - BRANCH=9: `ALUSrcA`=1, `ALUSrcB`=00, SUB, `PCWrCond`=1, `PCSrc`=01. Goes to FETCH.
  - JUMP=10: `PCWr`=1, `PCSrc`=10. Goes to FETCH.
  - ADDIEX=11: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Goes to ADDIWB.
  - ADDIWB=12: `RegWr`=1, `RegDst`=0, `Mem2Reg`=0. Goes to FETCH.
- `OpCode`/`Funct` are sampled only in DECODE and EXEC/ALUWB; the IR is stable there because `IRWr`=0.
- Undefined state codes (13–15) go to IDLE on the next edge.
- Cycle counts with `MemReady` constantly 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal encodings take 2 cycles.
- With MEM_WAIT=0, FETCH, MEMRD and MEMWR each last exactly 1 cycle regardless of `MemReady`.

Test Plan:
- Reset asserted asynchronously mid-MEMWR → all outputs 0 within the same cycle; `State`=0; `InstrCount`=0. Release reset → FETCH on the next edge.
- `MemReady`=1 constant; sequence lw, sw, add, beq, j, addi → state traces 1-2-3-4-5, 1-2-3-6, 1-2-7-8, 1-2-9, 1-2-10, 1-2-11-12. Every output is checked per cycle against the table; `InstrCount` ends at 6.
- MEM_WAIT=1 with `MemReady` low for 3 cycles in FETCH and in MEMRD → `IRWr`/`PCWr` each pulse exactly once, in the `MemReady` cycle. `MemRd` stays high for 4 cycles in each state. lw totals 11 cycles.
- R-type with `Funct` = 000000, and opcode 111111 → `Illegal`=1 for one cycle in DECODE, then FETCH; no `RegWr`/`MemWr`/`PCWr` asserted.
- ENABLE_ADDI=0 with opcode 001000 → `Illegal` pulse; ENABLE_ADDI=1 → ADDIEX with `ALUSrcB`=10 and `ALUCtr`=0010.
- CNT_W=4: fetch 17 instructions → `InstrCount` wraps 15→0 and ends at 1. MEM_WAIT=0 with `MemReady` tied to 0 → an add still completes in 4 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences each instruction over 3-5 states, drives datapath
// selects and write enables, waits on MemReady for memory states and counts fetches.
module multicycle_controller #(
    parameter int unsigned MEM_WAIT    = 1,
    parameter int unsigned ENABLE_ADDI = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IRWr,
    output logic             RegDst,
    output logic             RegWr,
    output logic             Mem2Reg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [3:0]       ALUCtr,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StMemAdr = 4'd3;
    localparam logic [3:0] StMemRd  = 4'd4;
    localparam logic [3:0] StMemWb  = 4'd5;
    localparam logic [3:0] StMemWr  = 4'd6;
    localparam logic [3:0] StExec   = 4'd7;
    localparam logic [3:0] StAluWb  = 4'd8;
    localparam logic [3:0] StBranch = 4'd9;
    localparam logic [3:0] StJump   = 4'd10;
    localparam logic [3:0] StAddiEx = 4'd11;
    localparam logic [3:0] StAddiWb = 4'd12;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             r_is_sw;
    logic [3:0]       r_alu_ctr;
    logic [CNT_W-1:0] r_count;
    logic             w_ready;
    logic             w_rtype_ok;
    logic [3:0]       w_funct_alu;
    logic             w_dec_illegal;
    logic [3:0]       w_dec_next;

    // Without the wait handshake every memory access completes in one cycle.
    assign w_ready    = (MEM_WAIT == 0) ? 1'b1 : MemReady;
    assign State      = r_state;
    assign InstrCount = r_count;

    always_comb begin
        w_rtype_ok  = 1'b1;
        w_funct_alu = AluAdd;
        case (Funct)
            FnAdd:   w_funct_alu = AluAdd;
            FnSub:   w_funct_alu = AluSub;
            FnAnd:   w_funct_alu = AluAnd;
            FnOr:    w_funct_alu = AluOr;
            FnSlt:   w_funct_alu = AluSlt;
            default: w_rtype_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_dec_next    = StFetch;
        w_dec_illegal = 1'b0;
        case (OpCode)
            OpRtype: begin
                if (w_rtype_ok) w_dec_next = StExec;
                else            w_dec_illegal = 1'b1;
            end
            OpLw, OpSw: w_dec_next = StMemAdr;
            OpBeq:      w_dec_next = StBranch;
            OpJ:        w_dec_next = StJump;
            OpAddi: begin
                if (ENABLE_ADDI != 0) w_dec_next = StAddiEx;
                else                  w_dec_illegal = 1'b1;
            end
            default:    w_dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next = StIdle;
        case (r_state)
            StIdle:   w_next = StFetch;
            StFetch:  w_next = w_ready ? StDecode : StFetch;
            StDecode: w_next = w_dec_next;
            StMemAdr: w_next = r_is_sw ? StMemWr : StMemRd;
            StMemRd:  w_next = w_ready ? StMemWb : StMemRd;
            StMemWb:  w_next = StFetch;
            StMemWr:  w_next = w_ready ? StFetch : StMemWr;
            StExec:   w_next = StAluWb;
            StAluWb:  w_next = StFetch;
            StBranch: w_next = StFetch;
            StJump:   w_next = StFetch;
            StAddiEx: w_next = StAddiWb;
            StAddiWb: w_next = StFetch;
            default:  w_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_is_sw   <= 1'b0;
            r_alu_ctr <= AluAnd;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            // lw/sw selection is captured while the IR is known stable in DECODE.
            if (r_state == StDecode) r_is_sw <= (OpCode == OpSw);
            if (r_state == StExec) r_alu_ctr <= w_funct_alu;
            if ((r_state == StFetch) && w_ready) r_count <= r_count + CntOne;
        end
    end

    always_comb begin
        PCWr     = 1'b0;
        PCWrCond = 1'b0;
        IorD     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        IRWr     = 1'b0;
        RegDst   = 1'b0;
        RegWr    = 1'b0;
        Mem2Reg  = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        ALUCtr   = AluAdd;
        Illegal  = 1'b0;
        case (r_state)
            StIdle: ALUCtr = AluAnd;
            StFetch: begin
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                IRWr    = w_ready;
                PCWr    = w_ready;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                Illegal = w_dec_illegal;
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
            end
            StMemWb: begin
                RegWr   = 1'b1;
                Mem2Reg = 1'b1;
            end
            StMemWr: begin
                MemWr = 1'b1;
                IorD  = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUCtr  = w_funct_alu;
            end
            StAluWb: begin
                RegWr  = 1'b1;
                RegDst = 1'b1;
                ALUCtr = r_alu_ctr;
            end
            StBranch: begin
                ALUSrcA  = 1'b1;
                ALUCtr   = AluSub;
                PCWrCond = 1'b1;
                PCSrc    = 2'b01;
            end
            StJump: begin
                PCWr  = 1'b1;
                PCSrc = 2'b10;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StAddiWb: RegWr = 1'b1;
            default:  ALUCtr = AluAnd;
        endcase
    end

endmodule
